// File: rtl/credit_fifo_pkg.sv
// Shared sizing helpers for the credit-tracked FIFO and its neighbouring blocks.
package credit_fifo_pkg;

   // Width able to hold every value 0..depth, e.g. an occupancy or credit count.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer width; a single-entry buffer still needs a one-bit pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Unreset register-array storage: one write port, one combinational read port.
module fifo_ram
   import credit_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [ptr_width(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic [ptr_width(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]            rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/credit_fifo.sv
// Show-ahead FIFO behind a fixed-latency pipeline; issue credits guarantee
// every word in flight has a slot by the time it arrives.
module credit_fifo
   import credit_fifo_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        issue,
   output logic                        issue_ready,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic [cnt_width(DEPTH)-1:0] inflight,
   output logic                        overflow
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam int AW = CW + 1;

   logic [CW-1:0]    count_reg, count_next;
   logic [CW-1:0]    inflight_reg, inflight_next;
   logic [PW-1:0]    wptr_reg, wptr_next;
   logic [PW-1:0]    rptr_reg, rptr_next;
   logic             overflow_reg, overflow_next;

   logic [AW-1:0]    credit_sum;
   logic             full;
   logic             issue_fire;
   logic             push;
   logic             pop;
   logic             wr_en;
   logic             arrival;
   logic [WIDTH-1:0] rd_data;

   // Credits come from registered state only, so a same-cycle pop never
   // reopens issue; the extra bit keeps count + inflight from wrapping.
   assign credit_sum  = {1'b0, count_reg} + {1'b0, inflight_reg};
   assign issue_ready = credit_sum < AW'(DEPTH);
   assign full        = {1'b0, count_reg} == AW'(DEPTH);

   assign issue_fire  = issue & issue_ready;
   assign push        = in_valid;
   assign pop         = out_valid & out_ready;
   assign wr_en       = push & (~full | pop);
   // Words issued before a reset arrive with no credit outstanding.
   assign arrival     = push & (inflight_reg != '0);

   always_comb begin
      count_next    = count_reg + CW'(wr_en) - CW'(pop);
      inflight_next = inflight_reg + CW'(issue_fire) - CW'(arrival);
      wptr_next     = wptr_reg;
      rptr_next     = rptr_reg;
      overflow_next = overflow_reg;
      if (wr_en) begin
         wptr_next = (wptr_reg == PW'(DEPTH - 1)) ? '0 : wptr_reg + PW'(1);
      end
      if (pop) begin
         rptr_next = (rptr_reg == PW'(DEPTH - 1)) ? '0 : rptr_reg + PW'(1);
      end
      if (push && full && !pop) begin
         overflow_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg    <= '0;
         inflight_reg <= '0;
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         count_reg    <= count_next;
         inflight_reg <= inflight_next;
         wptr_reg     <= wptr_next;
         rptr_reg     <= rptr_next;
         overflow_reg <= overflow_next;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr_reg),
      .wr_data (in_data),
      .rd_addr (rptr_reg),
      .rd_data (rd_data)
   );

   assign out_valid = count_reg != '0;
   assign out_data  = out_valid ? rd_data : RESET_VALUE;
   assign count     = count_reg;
   assign inflight  = inflight_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_credit_fifo.sv
// Directed bench for credit_fifo (DEPTH=4) fed through a 3-cycle delay model.
module tb_credit_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       issue;
   logic       issue_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] count;
   logic [2:0] inflight;
   logic       overflow;

   logic [7:0] issue_data;
   logic       force_valid;
   logic [7:0] force_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Upstream delay stage, CYCLES=3, write gated by issue_ready.
   logic       p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
   logic [7:0] d0 = '0, d1 = '0, d2 = '0;
   always @(posedge clk) begin
      p0 <= issue & issue_ready & rst_n;
      d0 <= issue_data;
      p1 <= p0;
      d1 <= d0;
      p2 <= p1;
      d2 <= d1;
   end
   assign in_valid = p2 | force_valid;
   assign in_data  = force_valid ? force_data : d2;

   credit_fifo #(
      .WIDTH       (8),
      .DEPTH       (4),
      .RESET_VALUE (8'h00)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue       (issue),
      .issue_ready (issue_ready),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .inflight    (inflight),
      .overflow    (overflow)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] drain_exp [4];
      int nxt;
      int expv;
      logic tog;
      logic fire_now;

      rst_n       = 1'b0;
      issue       = 1'b0;
      issue_data  = '0;
      out_ready   = 1'b0;
      force_valid = 1'b0;
      force_data  = '0;

      // Reset values
      repeat (3) tick();
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_out_data",    32'(out_data),    32'h00);
      chk("rst_count",       32'(count),       32'd0);
      chk("rst_inflight",    32'(inflight),    32'd0);
      chk("rst_overflow",    32'(overflow),    32'd0);
      issue = 1'b1;
      tick();
      chk("rst_issue_inflight", 32'(inflight), 32'd0);
      issue = 1'b0;
      rst_n = 1'b1;
      tick();

      // Credit stall: four issues fit, the fifth is held off
      issue      = 1'b1;
      issue_data = 8'h01;
      for (int i = 1; i <= 7; i++) begin
         tick();
         issue_data = 8'(i + 1);
         chk($sformatf("stall_ready_%0d", i), 32'(issue_ready), (i <= 3) ? 32'd1 : 32'd0);
      end
      issue = 1'b0;
      chk("stall_count",    32'(count),     32'd4);
      chk("stall_inflight", 32'(inflight),  32'd0);
      chk("stall_overflow", 32'(overflow),  32'd0);
      chk("stall_head",     32'(out_data),  32'h01);

      // Full with simultaneous push and pop
      force_valid = 1'b1;
      force_data  = 8'h55;
      out_ready   = 1'b1;
      tick();
      force_valid = 1'b0;
      out_ready   = 1'b0;
      chk("fullpp_count",    32'(count),    32'd4);
      chk("fullpp_head",     32'(out_data), 32'h02);
      chk("fullpp_overflow", 32'(overflow), 32'd0);

      // Forced overflow: push while full without pop
      force_valid = 1'b1;
      force_data  = 8'hAA;
      tick();
      force_valid = 1'b0;
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_count", 32'(count),    32'd4);
      tick();
      chk("ovf_sticky", 32'(overflow),    32'd1);
      chk("ovf_ready",  32'(issue_ready), 32'd0);
      drain_exp[0] = 8'h02;
      drain_exp[1] = 8'h03;
      drain_exp[2] = 8'h04;
      drain_exp[3] = 8'h55;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_drain_%0d", k), 32'(out_data), 32'(drain_exp[k]));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty_valid", 32'(out_valid), 32'd0);
      chk("drain_empty_data",  32'(out_data),  32'h00);
      chk("drain_overflow",    32'(overflow),  32'd1);

      // Ordering and wrap: 0x01..0x0A with out_ready toggling
      nxt  = 1;
      expv = 1;
      tog  = 1'b1;
      for (int c = 0; c < 100 && expv <= 10; c++) begin
         issue      = (nxt <= 10);
         issue_data = 8'(nxt);
         out_ready  = tog;
         tog        = ~tog;
         fire_now   = issue & issue_ready;
         if (out_valid && out_ready) begin
            chk($sformatf("order_%0d", expv), 32'(out_data), 32'(expv));
            expv++;
         end
         tick();
         if (fire_now) nxt++;
      end
      issue     = 1'b0;
      out_ready = 1'b0;
      chk("order_done",     32'(expv),     32'd11);
      chk("order_count",    32'(count),    32'd0);
      chk("order_inflight", 32'(inflight), 32'd0);

      // Reset mid-stream with count=2, inflight=2
      issue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue_data = 8'(8'hB1 + i);
         tick();
      end
      issue = 1'b0;
      tick();
      chk("pre_rst_count",    32'(count),    32'd2);
      chk("pre_rst_inflight", 32'(inflight), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_count",       32'(count),       32'd0);
      chk("mid_rst_inflight",    32'(inflight),    32'd0);
      chk("mid_rst_out_valid",   32'(out_valid),   32'd0);
      chk("mid_rst_out_data",    32'(out_data),    32'h00);
      chk("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("mid_rst_overflow",    32'(overflow),    32'd0);
      #1 rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_count",    32'(count),    32'd2);
      chk("post_rst_inflight", 32'(inflight), 32'd0);
      chk("post_rst_overflow", 32'(overflow), 32'd0);
      chk("post_rst_head",     32'(out_data), 32'hB3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_rst_second", 32'(out_data), 32'hB4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
